a2x_copro15_regs: RTL
=====================

Name: a2x_copro15_regs

Overview:
Parametrised successor to the Amber CP15 register block. It adds configurable region-map width, a multi-entry fault queue with overflow detection, and a request/acknowledge cache-flush handshake in place of a one-cycle pulse. It sits beside the core's execute stage and feeds cache configuration to the cache controller.

Parameters:
REGION_BITS, 32, width of cacheable/updateable/disruptive area maps; legal range 1..32; each bit covers 2MB.
FAULT_DEPTH, 4, fault queue entries; power of 2; legal range 2..128.
COPRO_ID, 32'h4156_0301, value returned by the ID register.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_fetch_stall  in  1  freezes register, queue and read-data updates
i_copro_crn  in  4  register number
i_copro_operation  in  2  2'd2 = write (MCR); other values have no write effect
i_copro_write_data  in  32  write data
i_fault  in  1  fault push request
i_fault_status  in  8  fault status
i_fault_address  in  32  faulting address
i_cache_flush_ack  in  1  cache controller has completed the flush
o_copro_read_data  out  32  registered read data
o_cache_control  out  3  cache_control register
o_cacheable_area  out  REGION_BITS  cacheable map
o_updateable_area  out  REGION_BITS  updateable map
o_disruptive_area  out  REGION_BITS  disruptive map
o_cache_flush  out  1  flush request, held until acknowledged
o_fault_overflow  out  1  sticky queue-overflow flag

Behaviour:
- Reset (i_rst async, active-high): all registers, queue pointers and count, the overflow flag, o_cache_flush and o_copro_read_data clear to 0. The FSM goes to IDLE. A reset mid-flush drops the request.
- Definition: wr = !i_fetch_stall && i_copro_operation==2'd2.
- Writes by crn:
  - 2: cache_control <= wdata[2:0]
  - 3, 4, 5: area maps <= wdata[REGION_BITS-1:0]
  - 6: pop the fault queue head; if wdata[31]=1, also clear the overflow flag
  - 1: flush request
  - all others: ignored
- Reads: o_copro_read_data updates on the clock edge when !i_fetch_stall and holds while stalled. Latency is 1 cycle. A same-cycle write is not visible; the read returns the pre-write value.
- Read map by crn:
  - 0: COPRO_ID
  - 2: {29'd0, cache_control}
  - 3, 4, 5: area map, zero-extended
  - 6: {overflow, 7'd0, count[7:0], 8'd0, head_status}
  - 7: head_address
  - 8: {16'd0, FAULT_DEPTH[7:0], 2'd0, REGION_BITS[5:0]}
  - all others: 0
- Reads of 6 and 7 when the queue is empty return 0 in the status and address fields; the overflow and count fields are still valid.
- Fault queue (circular FIFO, count width clog2(FAULT_DEPTH)+1):
  - Push when !i_fetch_stall && i_fault.
  - Push while full: entry dropped, overflow set (sticky).
  - Pop while empty: ignored.
  - Push and pop in the same cycle while full: both occur; count unchanged; overflow not set.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FAULT_DEPTH.
  - An overflow clear and an overflow set in the same cycle: set wins.
- Flush FSM:
  - States are IDLE and REQ; o_cache_flush = (state==REQ).
  - IDLE -> REQ on wr to crn 1.
  - REQ -> IDLE when i_cache_flush_ack=1. The ack is sampled regardless of i_fetch_stall.
  - A crn-1 write while in REQ merges into the pending request; if ack arrives in that same cycle, the FSM stays in REQ.
  - An ack while in IDLE is ignored.
- All register outputs are direct register values with no combinational path from inputs.

Test Plan:
- Reset then read crn 0 and crn 8 (defaults) -> 32'h4156_0301 and 32'h0000_0420 one cycle later; all outputs 0.
- Write crn 3 = 32'hFFFF_0001 with REGION_BITS=8 -> o_cacheable_area=8'h01; read crn 3 returns 32'h0000_0001. Repeat with i_fetch_stall=1 -> no change.
- Push 5 faults (status 8'h11..8'h15, address 32'h1000..32'h1004), DEPTH=4 -> count=4, overflow=1, crn 7 reads 32'h1000; four pops give 32'h1000..32'h1003; a fifth pop leaves count=0.
- With the queue full, pop and push (status 8'h77) in the same cycle -> count stays 4, overflow stays 0, new tail is 8'h77; write crn 6 with bit31=1 clears overflow.
- Write crn 1 -> o_cache_flush=1 next cycle, held for 10 cycles with no ack; ack -> 0 next cycle. Write crn 1 together with ack while in REQ -> remains 1.
- Assert i_rst asynchronously while in REQ with 3 queued faults -> o_cache_flush, count and overflow are 0 immediately.

Source files
------------

// File: rtl/a2x_copro15_regs.sv
// Coprocessor-15 style control register block: cache configuration, region maps,
// a fault FIFO with sticky overflow, and a request/acknowledge cache-flush handshake.
module a2x_copro15_regs #(
  parameter int          REGION_BITS = 32,
  parameter int          FAULT_DEPTH = 4,
  parameter logic [31:0] COPRO_ID    = 32'h4156_0301
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fetch_stall,
  input  logic [3:0]             i_copro_crn,
  input  logic [1:0]             i_copro_operation,
  input  logic [31:0]            i_copro_write_data,
  input  logic                   i_fault,
  input  logic [7:0]             i_fault_status,
  input  logic [31:0]            i_fault_address,
  input  logic                   i_cache_flush_ack,
  output logic [31:0]            o_copro_read_data,
  output logic [2:0]             o_cache_control,
  output logic [REGION_BITS-1:0] o_cacheable_area,
  output logic [REGION_BITS-1:0] o_updateable_area,
  output logic [REGION_BITS-1:0] o_disruptive_area,
  output logic                   o_cache_flush,
  output logic                   o_fault_overflow
);

  localparam int          PW        = $clog2(FAULT_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] INFO_WORD = {16'd0, 8'(FAULT_DEPTH), 2'd0, 6'(REGION_BITS)};

  typedef enum logic {IDLE, REQ} flush_state_t;

  flush_state_t           state_q, state_d;
  logic [2:0]             cache_control_q, cache_control_d;
  logic [REGION_BITS-1:0] cacheable_q, cacheable_d;
  logic [REGION_BITS-1:0] updateable_q, updateable_d;
  logic [REGION_BITS-1:0] disruptive_q, disruptive_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            read_data_q, read_data_d;

  logic [7:0]             status_mem [FAULT_DEPTH];
  logic [31:0]            addr_mem   [FAULT_DEPTH];

  logic wr, flush_wr, pop_req, push_req, empty, full, do_pop, do_push;
  logic [7:0]  head_status;
  logic [31:0] head_address;

  always_comb begin
    wr       = !i_fetch_stall && (i_copro_operation == 2'd2);
    flush_wr = wr && (i_copro_crn == 4'd1);
    pop_req  = wr && (i_copro_crn == 4'd6);
    push_req = !i_fetch_stall && i_fault;
    empty    = (count_q == '0);
    full     = (count_q == CW'(FAULT_DEPTH));
    do_pop   = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    do_push  = push_req && (!full || do_pop);
    head_status  = empty ? 8'd0  : status_mem[rd_ptr_q];
    head_address = empty ? 32'd0 : addr_mem[rd_ptr_q];
  end

  always_comb begin
    cache_control_d = cache_control_q;
    cacheable_d     = cacheable_q;
    updateable_d    = updateable_q;
    disruptive_d    = disruptive_q;
    if (wr) begin
      case (i_copro_crn)
        4'd2:    cache_control_d = i_copro_write_data[2:0];
        4'd3:    cacheable_d     = i_copro_write_data[REGION_BITS-1:0];
        4'd4:    updateable_d    = i_copro_write_data[REGION_BITS-1:0];
        4'd5:    disruptive_d    = i_copro_write_data[REGION_BITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    overflow_d = overflow_q;
    if (pop_req && i_copro_write_data[31])
      overflow_d = 1'b0;
    if (push_req && full && !do_pop)
      overflow_d = 1'b1;
  end

  always_comb begin
    read_data_d = read_data_q;
    if (!i_fetch_stall) begin
      case (i_copro_crn)
        4'd0:    read_data_d = COPRO_ID;
        4'd2:    read_data_d = {29'd0, cache_control_q};
        4'd3:    read_data_d = 32'(cacheable_q);
        4'd4:    read_data_d = 32'(updateable_q);
        4'd5:    read_data_d = 32'(disruptive_q);
        4'd6:    read_data_d = {overflow_q, 7'd0, 8'(count_q), 8'd0, head_status};
        4'd7:    read_data_d = head_address;
        4'd8:    read_data_d = INFO_WORD;
        default: read_data_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_wr) state_d = REQ;
      // A fresh request arriving with the ack keeps the handshake open.
      REQ:     if (i_cache_flush_ack && !flush_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      cache_control_q <= '0;
      cacheable_q     <= '0;
      updateable_q    <= '0;
      disruptive_q    <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overflow_q      <= 1'b0;
      read_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      cache_control_q <= cache_control_d;
      cacheable_q     <= cacheable_d;
      updateable_q    <= updateable_d;
      disruptive_q    <= disruptive_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overflow_q      <= overflow_d;
      read_data_q     <= read_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      status_mem[wr_ptr_q] <= i_fault_status;
      addr_mem[wr_ptr_q]   <= i_fault_address;
    end
  end

  assign o_copro_read_data = read_data_q;
  assign o_cache_control   = cache_control_q;
  assign o_cacheable_area  = cacheable_q;
  assign o_updateable_area = updateable_q;
  assign o_disruptive_area = disruptive_q;
  assign o_cache_flush     = (state_q == REQ);
  assign o_fault_overflow  = overflow_q;

endmodule
